// File: rtl/opb_sw_reg_sequencer.sv
// -----------------------------------------------------------------------------
// opb_sw_reg_sequencer
//
// OPB slave that fronts a bank of PPC software registers for one firmware
// block. Word offsets 0..N_WR-1 are PPC-writable control registers; offsets
// N_WR..N_WR+N_RD-1 are fabric status registers. Each status read goes
// through a cap_req/cap_ack handshake, so the value returned is an atomic
// snapshot. Every output is registered.
//
// Ports
//   OPB_Clk, OPB_Rst      clock, synchronous active-high reset
//   OPB_ABus/BE/DBus/RNW  OPB request (big-endian bit numbering, bit 0 = MSB)
//   OPB_select            transfer request
//   OPB_seqAddr           ignored, every access is single-beat
//   Sl_DBus               read data, zero outside the ack cycle
//   Sl_xferAck/errAck     transfer / error completion
//   Sl_retry              tied low
//   Sl_toutSup            timeout suppress while waiting on the fabric
//   wr_regs, wr_strobe    control registers and per-register write pulse
//   cap_req, cap_idx      capture request and status register index
//   cap_data, cap_ack     fabric snapshot and its acknowledge
//   err_sticky            set on any error completion, cleared by reset
// -----------------------------------------------------------------------------
module opb_sw_reg_sequencer #(
    parameter logic [31:0] C_BASEADDR   = 32'h0110_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0110_00FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          N_WR         = 4,
    parameter int          N_RD         = 4,
    parameter int          CAP_TIMEOUT  = 16
) (
    input  logic               OPB_Clk,
    input  logic               OPB_Rst,
    input  logic [0:31]        OPB_ABus,
    input  logic [0:3]         OPB_BE,
    input  logic [0:31]        OPB_DBus,
    input  logic               OPB_RNW,
    input  logic               OPB_select,
    input  logic               OPB_seqAddr,
    output logic [0:31]        Sl_DBus,
    output logic               Sl_errAck,
    output logic               Sl_retry,
    output logic               Sl_toutSup,
    output logic               Sl_xferAck,
    output logic [N_WR*32-1:0] wr_regs,
    output logic [N_WR-1:0]    wr_strobe,
    output logic               cap_req,
    output logic [7:0]         cap_idx,
    input  logic [31:0]        cap_data,
    input  logic               cap_ack,
    output logic               err_sticky
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_ACK,
        S_HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [N_WR*32-1:0]  wr_regs_q, wr_regs_d;
    logic [N_WR-1:0]     wr_strobe_q, wr_strobe_d;
    logic                cap_req_q, cap_req_d;
    logic [7:0]          cap_idx_q, cap_idx_d;
    logic                tout_sup_q, tout_sup_d;
    logic [31:0]         sl_dbus_q, sl_dbus_d;
    logic                xfer_ack_q, xfer_ack_d;
    logic                err_ack_q, err_ack_d;
    logic                err_sticky_q, err_sticky_d;

    // Bus fields re-expressed in descending numeric order: BE[0] ends up on
    // be[3] and gates the most significant byte.
    logic [31:0] abus;
    logic [31:0] dbus;
    logic [3:0]  be;
    logic        hit;
    logic [31:0] addr_diff;
    logic [31:0] word_off;

    assign abus      = OPB_ABus;
    assign dbus      = OPB_DBus;
    assign be        = OPB_BE;
    assign hit       = OPB_select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
    assign addr_diff = abus - C_BASEADDR;
    assign word_off  = addr_diff >> 2;

    logic unused_ok;
    assign unused_ok = ^{OPB_seqAddr, C_OPB_AWIDTH[0], C_OPB_DWIDTH[0]};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_regs_d    = wr_regs_q;
        wr_strobe_d  = '0;
        cap_req_d    = cap_req_q;
        cap_idx_d    = cap_idx_q;
        tout_sup_d   = tout_sup_q;
        sl_dbus_d    = '0;
        xfer_ack_d   = 1'b0;
        err_ack_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    if (word_off < 32'(N_WR)) begin
                        state_d    = S_ACK;
                        xfer_ack_d = 1'b1;
                        for (int unsigned k = 0; k < N_WR; k++) begin
                            if (word_off == 32'(k)) begin
                                if (OPB_RNW) begin
                                    sl_dbus_d = wr_regs_q[k*32 +: 32];
                                end else begin
                                    wr_strobe_d[k] = 1'b1;
                                    for (int unsigned b = 0; b < 4; b++) begin
                                        if (be[b]) begin
                                            wr_regs_d[k*32 + b*8 +: 8] = dbus[b*8 +: 8];
                                        end
                                    end
                                end
                            end
                        end
                    end else if ((word_off < 32'(N_WR + N_RD)) && OPB_RNW) begin
                        state_d    = S_CAPTURE;
                        cap_req_d  = 1'b1;
                        tout_sup_d = 1'b1;
                        cap_idx_d  = 8'(word_off - 32'(N_WR));
                        cnt_d      = '0;
                    end else begin
                        // Status-register write or unmapped offset inside the window.
                        state_d    = S_ACK;
                        xfer_ack_d = 1'b1;
                        err_ack_d  = 1'b1;
                    end
                end
            end

            S_CAPTURE: begin
                // Master abort wins over a coincident cap_ack; ack wins over timeout.
                if (!OPB_select) begin
                    state_d    = S_IDLE;
                    cap_req_d  = 1'b0;
                    tout_sup_d = 1'b0;
                end else if (cap_ack) begin
                    state_d    = S_ACK;
                    cap_req_d  = 1'b0;
                    tout_sup_d = 1'b0;
                    xfer_ack_d = 1'b1;
                    sl_dbus_d  = cap_data;
                end else if (cnt_q == 8'(CAP_TIMEOUT - 1)) begin
                    state_d    = S_ACK;
                    cap_req_d  = 1'b0;
                    tout_sup_d = 1'b0;
                    xfer_ack_d = 1'b1;
                    err_ack_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_ACK: begin
                state_d = S_HOLD;
            end

            S_HOLD: begin
                if (!OPB_select) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        err_sticky_d = err_sticky_q | err_ack_d;
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            wr_regs_q    <= '0;
            wr_strobe_q  <= '0;
            cap_req_q    <= 1'b0;
            cap_idx_q    <= '0;
            tout_sup_q   <= 1'b0;
            sl_dbus_q    <= '0;
            xfer_ack_q   <= 1'b0;
            err_ack_q    <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_regs_q    <= wr_regs_d;
            wr_strobe_q  <= wr_strobe_d;
            cap_req_q    <= cap_req_d;
            cap_idx_q    <= cap_idx_d;
            tout_sup_q   <= tout_sup_d;
            sl_dbus_q    <= sl_dbus_d;
            xfer_ack_q   <= xfer_ack_d;
            err_ack_q    <= err_ack_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign Sl_DBus    = sl_dbus_q;
    assign Sl_errAck  = err_ack_q;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = tout_sup_q;
    assign Sl_xferAck = xfer_ack_q;
    assign wr_regs    = wr_regs_q;
    assign wr_strobe  = wr_strobe_q;
    assign cap_req    = cap_req_q;
    assign cap_idx    = cap_idx_q;
    assign err_sticky = err_sticky_q;

endmodule
